// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and 8N1 constants.
package uart_program_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic UART_STOP_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_COUNT,
    LD_DATA,
    LD_CHECK
  } ld_state_e;

endpackage

// File: rtl/uart_program_loader_if.sv
// Text-memory write port: the loader drives it, the instruction memory receives it.
interface uart_program_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);

endinterface

// File: rtl/uart_program_loader_uart_rx_byte.sv
// 8N1 UART byte receiver with two-flop synchronizer and centre sampling.
//
// state    | meaning
// RX_IDLE  | line idle, watching for a falling edge
// RX_START | half a bit after the edge; re-check start bit (high = false start)
// RX_DATA  | sampling 8 data bits LSB first at bit centres
// RX_STOP  | sampling stop bit; high -> valid, low -> frame_err
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int TW = (CLKS_PER_BIT > 4) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;

  // State, synchronizer and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RX_IDLE;
      sync1_q     <= UART_IDLE_LEVEL;
      sync2_q     <= UART_IDLE_LEVEL;
      prev_q      <= UART_IDLE_LEVEL;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Bit timing and next-state logic; valid/frame_err land one cycle after the stop sample
  always_comb begin
    state_d     = state_q;
    sync1_d     = rx_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (timer_q != '0) timer_d = timer_q - 1'b1;

    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          timer_d = HALF_BIT;
        end
      end
      RX_START: begin
        if (timer_q == '0) begin
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            timer_d   = FULL_BIT;
            bit_idx_d = '0;
          end
        end
      end
      RX_DATA: begin
        if (timer_q == '0) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          timer_d   = FULL_BIT;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (timer_q == '0) begin
          state_d = RX_IDLE;
          if (sync2_q == UART_STOP_LEVEL) valid_d = 1'b1;
          else                            frame_err_d = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data      = shift_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a framed program from UART into text memory and holds the core until it checks out.
//
// state    | meaning
// LD_IDLE  | waiting for the sync byte; other bytes ignored
// LD_COUNT | next byte is N (word count - 1)
// LD_DATA  | assembling little-endian words, writing each on its 4th byte
// LD_CHECK | next byte is the XOR checksum of all data bytes
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          ADDR_WIDTH   = 8,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int          TIMEOUT_BITS = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  uart_program_loader_if.master   imem,
  output logic                    core_hold,
  output logic                    loading,
  output logic                    done,
  output logic                    error
);

  localparam int CW         = ADDR_WIDTH + 2;
  localparam int TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TOW        = $clog2(TO_CYCLES + 1);
  localparam logic [TOW-1:0] TO_RELOAD = TOW'(TO_CYCLES - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (uart_rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_frame_err)
  );

  ld_state_e             state_q, state_d;
  logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] last_word_q, last_word_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            chk_q, chk_d;
  logic [TOW-1:0]        timer_q, timer_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_hold_q, core_hold_d;
  logic                  loading_q, loading_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  // Loader state and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= LD_IDLE;
      byte_cnt_q   <= '0;
      last_word_q  <= '0;
      word_q       <= '0;
      chk_q        <= '0;
      timer_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      last_word_q  <= last_word_d;
      word_q       <= word_d;
      chk_q        <= chk_d;
      timer_q      <= timer_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      loading_q    <= loading_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Frame parsing, word assembly, checksum and inter-byte timeout
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    last_word_d  = last_word_q;
    word_d       = word_q;
    chk_d        = chk_q;
    timer_d      = timer_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_hold_d  = core_hold_q;
    loading_d    = loading_q;
    done_d       = 1'b0;
    error_d      = error_q;

    if (timer_q != '0) timer_d = timer_q - 1'b1;

    if (rx_frame_err) begin
      // A corrupted byte poisons any frame in flight; the core stays held if it was.
      error_d   = 1'b1;
      loading_d = 1'b0;
      state_d   = LD_IDLE;
    end else if (rx_valid) begin
      timer_d = TO_RELOAD;
      unique case (state_q)
        LD_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d     = LD_COUNT;
            error_d     = 1'b0;
            loading_d   = 1'b1;
            core_hold_d = 1'b1;
            byte_cnt_d  = '0;
            chk_d       = '0;
          end
        end
        LD_COUNT: begin
          if (int'(rx_data) >= (1 << ADDR_WIDTH)) begin
            error_d   = 1'b1;
            loading_d = 1'b0;
            state_d   = LD_IDLE;
          end else begin
            last_word_d = ADDR_WIDTH'(rx_data);
            state_d     = LD_DATA;
          end
        end
        LD_DATA: begin
          word_d = {rx_data, word_q[23:8]};
          chk_d  = chk_q ^ rx_data;
          if (byte_cnt_q[1:0] == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = byte_cnt_q[CW-1:2];
            imem_wdata_d = {rx_data, word_q};
          end
          // Byte index tops out at 4*words-1, so the counter never wraps.
          if (byte_cnt_q == {last_word_q, 2'b11}) state_d = LD_CHECK;
          else                                    byte_cnt_d = byte_cnt_q + 1'b1;
        end
        LD_CHECK: begin
          state_d   = LD_IDLE;
          loading_d = 1'b0;
          if (rx_data == chk_q) begin
            done_d      = 1'b1;
            core_hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
        default: state_d = LD_IDLE;
      endcase
    end else if (state_q != LD_IDLE && timer_q == '0) begin
      error_d   = 1'b1;
      loading_d = 1'b0;
      state_d   = LD_IDLE;
    end
  end

  assign imem.imem_we    = imem_we_q;
  assign imem.imem_addr  = imem_addr_q;
  assign imem.imem_wdata = imem_wdata_q;
  assign core_hold       = core_hold_q;
  assign loading         = loading_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: table of whole frames plus hand-written corner cases.
module tb_uart_program_loader;

  localparam int CPB    = 8;
  localparam int AW     = 2;
  localparam int TOB    = 40;
  localparam int TO_CYC = TOB * CPB;
  localparam int NVEC   = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rx = 1'b1;
  logic core_hold, loading, done, error;

  uart_program_loader_if #(.ADDR_WIDTH(AW)) imem_bus ();

  uart_program_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .imem     (imem_bus),
    .core_hold(core_hold),
    .loading  (loading),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Write/done monitor, sampled away from the active edge
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            done_cnt = 0;
  int            bad_we   = 0;

  always @(negedge clk) begin
    if (imem_bus.imem_we) begin
      wr_addr.push_back(imem_bus.imem_addr);
      wr_data.push_back(imem_bus.imem_wdata);
      if (!loading) bad_we++;
    end
    if (done) done_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Frame bytes are right-aligned in reading order: byte 0 is the most significant.
  typedef struct packed {
    logic [159:0] bytes;
    int           nb;
    int           nw;
    logic [127:0] wd;
    logic         err;
    logic         hold;
    int           ndone;
  } vec_t;

  vec_t vecs[NVEC];
  int   wb, db, nb;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Data XOR for the two-word program: 0x13 ^ 0x93 ^ 0x10 = 0x90.
    vecs[0] = '{160'hA5_01_13_00_00_00_93_00_10_00_90, 11, 2,
                {32'h0, 32'h0, 32'h00100093, 32'h00000013}, 1'b0, 1'b0, 1};
    vecs[1] = '{160'hA5_01_13_00_00_00_93_00_10_00_81, 11, 2,
                {32'h0, 32'h0, 32'h00100093, 32'h00000013}, 1'b1, 1'b1, 0};
    vecs[2] = '{160'hA5_01_13_00_00_00_93_00_10_00_90, 11, 2,
                {32'h0, 32'h0, 32'h00100093, 32'h00000013}, 1'b0, 1'b0, 1};
    vecs[3] = '{160'h3C_5A, 2, 0, 128'h0, 1'b0, 1'b0, 0};
    vecs[4] = '{160'hA5_04, 2, 0, 128'h0, 1'b1, 1'b1, 0};
    vecs[5] = '{160'hA5_03_44_33_22_11_88_77_66_55_CC_BB_AA_99_01_FF_EE_DD_01, 19, 4,
                {32'hDDEEFF01, 32'h99AABBCC, 32'h55667788, 32'h11223344}, 1'b0, 1'b0, 1};
    vecs[6] = '{160'hA5_00_78_56_34_12_08, 7, 1,
                {32'h0, 32'h0, 32'h0, 32'h12345678}, 1'b0, 1'b0, 1};

    // Reset values
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst core_hold", core_hold, 1);
    check("rst loading", loading, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    check("rst imem_we", imem_bus.imem_we, 0);
    check("rst imem_addr", imem_bus.imem_addr, 0);

    // Reset in the middle of a byte inside a frame
    wb = wr_addr.size();
    send_bits(8'hA5, 1'b1);
    send_bits(8'h01, 1'b1);
    repeat (2) @(negedge clk);
    check("midrst loading before", loading, 1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB + CPB / 2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst core_hold", core_hold, 1);
    check("midrst loading", loading, 0);
    check("midrst imem_we", imem_bus.imem_we, 0);
    check("midrst done", done, 0);
    check("midrst error", error, 0);
    rst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("midrst writes", wr_addr.size() - wb, 0);
    check("midrst loading after", loading, 0);

    // Table of whole frames; state carries from one vector to the next
    for (int v = 0; v < NVEC; v++) begin
      wb = wr_addr.size();
      db = done_cnt;
      nb = vecs[v].nb;
      for (int k = 0; k < nb; k++) send_bits(vecs[v].bytes[8 * (nb - 1 - k) +: 8], 1'b1);
      repeat (2 * CPB) @(negedge clk);
      check($sformatf("v%0d writes", v), wr_addr.size() - wb, vecs[v].nw);
      for (int k = 0; k < vecs[v].nw; k++) begin
        if (wb + k < wr_addr.size()) begin
          check($sformatf("v%0d addr%0d", v, k), wr_addr[wb + k], k);
          check($sformatf("v%0d data%0d", v, k), wr_data[wb + k], vecs[v].wd[32 * k +: 32]);
        end
      end
      check($sformatf("v%0d error", v), error, vecs[v].err);
      check($sformatf("v%0d core_hold", v), core_hold, vecs[v].hold);
      check($sformatf("v%0d loading", v), loading, 0);
      check($sformatf("v%0d done pulses", v), done_cnt - db, vecs[v].ndone);
    end

    // Short glitch on idle line: no byte, no state change
    wb = wr_addr.size();
    db = done_cnt;
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch error", error, 0);
    check("glitch loading", loading, 0);
    check("glitch core_hold", core_hold, 0);
    check("glitch writes", wr_addr.size() - wb, 0);

    // Byte with a low stop bit
    send_bits(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("framing error", error, 1);
    check("framing loading", loading, 0);

    // Timeout inside a frame
    wb = wr_addr.size();
    send_bits(8'hA5, 1'b1);
    send_bits(8'h00, 1'b1);
    send_bits(8'h13, 1'b1);
    send_bits(8'h00, 1'b1);
    check("to loading", loading, 1);
    check("to error cleared", error, 0);
    check("to core_hold", core_hold, 1);
    repeat (TO_CYC - 3 * CPB) @(negedge clk);
    check("to early error", error, 0);
    check("to early loading", loading, 1);
    repeat (4 * CPB) @(negedge clk);
    check("to error", error, 1);
    check("to loading end", loading, 0);
    check("to core_hold end", core_hold, 1);
    check("to writes", wr_addr.size() - wb, 0);

    // Reset after the third word of a four-word frame
    wb = wr_addr.size();
    db = done_cnt;
    send_bits(8'hA5, 1'b1);
    send_bits(8'h03, 1'b1);
    for (int k = 0; k < 12; k++) send_bits(vecs[5].bytes[8 * (16 - k) +: 8], 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst3 writes", wr_addr.size() - wb, 3);
    if (wb + 2 < wr_addr.size()) check("rst3 last data", wr_data[wb + 2], 32'h99AABBCC);
    check("rst3 loading", loading, 0);
    check("rst3 core_hold", core_hold, 1);
    check("rst3 error", error, 0);
    send_bits(8'h01, 1'b1);
    send_bits(8'hFF, 1'b1);
    send_bits(8'hEE, 1'b1);
    send_bits(8'hDD, 1'b1);
    send_bits(8'h01, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("rst3 writes after", wr_addr.size() - wb, 3);
    check("rst3 done", done_cnt - db, 0);
    check("rst3 core_hold after", core_hold, 1);

    check("we while not loading", bad_we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
